// File: rtl/spi_main_mc.sv
// rtl/spi_main_mc.sv - multi-node SPI main with per-command mode, divider and CS-held bursts
module spi_main_mc #(
    parameter int NUM_NODES  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int NODE_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [NODE_W-1:0]     cmd_node,
    input  logic                  cmd_cpol,
    input  logic                  cmd_cpha,
    input  logic [DIV_WIDTH-1:0]  cmd_div,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_last,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_NODES-1:0]  cs_n
);

    localparam int EW = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [NODE_W-1:0]     node_q, node_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  last_q, last_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_NODES-1:0]  cs_n_q, cs_n_d;
    logic                  rsp_pend_q, rsp_pend_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic tick, leading, sample, last_edge, accept;
    logic [DATA_WIDTH-1:0] rx_shift;

    // Out-of-range node indices decode to no chip select at all.
    function automatic logic [NUM_NODES-1:0] cs_decode(input logic [NODE_W-1:0] n);
        logic [NUM_NODES-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_NODES; i++)
            if (n == NODE_W'(i)) r[i] = 1'b0;
        return r;
    endfunction

    assign tick      = (cnt_q == div_q);
    assign leading   = ~edge_q[0];
    assign sample    = leading ^ cpha_q;
    assign last_edge = (edge_q == LAST_EDGE);
    assign rx_shift  = {rx_q[DATA_WIDTH-2:0], miso};
    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != S_IDLE);
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            node_q      <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            last_q      <= 1'b0;
            div_q       <= '0;
            cnt_q       <= '0;
            edge_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= '1;
            rsp_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            node_q      <= node_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            last_q      <= last_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            edge_q      <= edge_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        last_d      = last_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        rsp_pend_d  = 1'b0;
        // The response is published the cycle after the final SCLK edge.
        rsp_valid_d = rsp_pend_q;
        rsp_data_d  = rsp_pend_q ? rx_q : rsp_data_q;

        case (state_q)
            S_IDLE: begin
                cs_n_d = '1;
                sclk_d = cpol_q;
                mosi_d = 1'b0;
                if (accept) begin
                    node_d  = cmd_node;
                    cpol_d  = cmd_cpol;
                    cpha_d  = cmd_cpha;
                    div_d   = cmd_div;
                    last_d  = cmd_last;
                    cs_n_d  = cs_decode(cmd_node);
                    sclk_d  = cmd_cpol;
                    mosi_d  = cmd_cpha ? 1'b0 : cmd_data[DATA_WIDTH-1];
                    tx_d    = cmd_cpha ? cmd_data : {cmd_data[DATA_WIDTH-2:0], 1'b0};
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (sample) rx_d = rx_shift;
                    // CPHA=0 launches on trailing edges, CPHA=1 on leading edges.
                    if ((cpha_q && leading) || (!cpha_q && !leading && !last_edge)) begin
                        mosi_d = tx_q[DATA_WIDTH-1];
                        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (last_edge) begin
                        rsp_pend_d = 1'b1;
                        state_d    = last_q ? S_TRAIL : S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TRAIL: begin
                mosi_d = 1'b0;
                if (tick) begin
                    cnt_d   = '0;
                    cs_n_d  = '1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                mosi_d = 1'b0;
                if (tick) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                mosi_d = 1'b0;
                sclk_d = cpol_q;
                // Burst continuation keeps the node and mode of the first word.
                if (accept) begin
                    div_d   = cmd_div;
                    last_d  = cmd_last;
                    mosi_d  = cpha_q ? 1'b0 : cmd_data[DATA_WIDTH-1];
                    tx_d    = cpha_q ? cmd_data : {cmd_data[DATA_WIDTH-2:0], 1'b0};
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = S_LEAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_main_mc.sv
// tb/tb_spi_main_mc.sv - directed self-checking bench for spi_main_mc
module tb_spi_main_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0, cmd_valid_b = 1'b0;
    logic [1:0] cmd_node = 2'd0;
    logic       cmd_cpol = 1'b0, cmd_cpha = 1'b0, cmd_last = 1'b1;
    logic [7:0] cmd_div = 8'd0, cmd_data = 8'd0;

    logic       cmd_ready, rsp_valid, busy, sclk, mosi;
    logic [7:0] rsp_data;
    logic [3:0] cs_n;
    logic       miso = 1'b0;

    logic       cmd_ready_b, rsp_valid_b, busy_b, sclk_b, mosi_b;
    logic [7:0] rsp_data_b;
    logic [2:0] cs_n_b;
    logic       miso_b = 1'b1;

    spi_main_mc #(.NUM_NODES(4), .DATA_WIDTH(8), .DIV_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_node(cmd_node), .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha), .cmd_div(cmd_div),
        .cmd_data(cmd_data), .cmd_last(cmd_last), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_main_mc #(.NUM_NODES(3), .DATA_WIDTH(8), .DIV_WIDTH(8)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_node(cmd_node), .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha), .cmd_div(cmd_div),
        .cmd_data(cmd_data), .cmd_last(cmd_last), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
    );

    int total = 0;
    int bad = 0;

    // Bench-side node model and bus observer, evaluated on the falling clk edge.
    logic [7:0] replies [2];
    logic       m_cpol = 1'b0, m_cpha = 1'b0;
    logic [3:0] exp_cs = 4'hF;

    int ncyc = 0, tog_cnt = 0, first_tog = -1, last_tog = -1, min_sp = 9999, max_sp = 0;
    int cs_bad = 0, cs_up = 0, onehot_bad = 0, mosi_rise_chg = 0, rsp_hi = 0;
    int rsp_cnt = 0, rsp_cyc = 0, acc_cnt = 0, bitc = 0, ri = 0;
    logic [7:0] rise_word = 8'd0, last_rsp = 8'd0, node_sr = 8'd0;
    logic       first_dir = 1'b0, prev_busy = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic [3:0] prev_cs = 4'hF;
    int tog_b = 0, rsp_cnt_b = 0, cs_low_b = 0;
    logic [7:0] last_rsp_b = 8'd0;
    logic       prev_busy_b = 1'b0, prev_sclk_b = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (busy && !prev_busy) begin
            tog_cnt = 0; first_tog = -1; last_tog = -1; min_sp = 9999; max_sp = 0;
            rise_word = 8'd0; cs_bad = 0; cs_up = 0; mosi_rise_chg = 0; rsp_hi = 0;
        end
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (rsp_valid) begin
            rsp_cnt++; rsp_hi++; rsp_cyc = ncyc; last_rsp = rsp_data;
        end
        if (cs_n != 4'hF && cs_n != exp_cs) cs_bad++;
        if ($countones(~cs_n) > 1) onehot_bad++;
        if (cs_n == 4'hF && prev_cs != 4'hF) cs_up++;
        if (cs_n != 4'hF && prev_cs == 4'hF) begin
            ri = 0; bitc = 0; node_sr = replies[0];
            if (!m_cpha) miso = node_sr[7];
        end
        if (prev_busy && sclk != prev_sclk) begin
            tog_cnt++;
            if (first_tog < 0) begin
                first_tog = ncyc; first_dir = sclk;
            end else begin
                if (ncyc - last_tog < min_sp) min_sp = ncyc - last_tog;
                if (ncyc - last_tog > max_sp) max_sp = ncyc - last_tog;
            end
            last_tog = ncyc;
            if (sclk) begin
                rise_word = {rise_word[6:0], prev_mosi};
                if (mosi != prev_mosi) mosi_rise_chg++;
            end
            if (cs_n != 4'hF) begin
                if (sclk != m_cpol) begin
                    if (m_cpha) begin
                        miso = node_sr[7]; node_sr = node_sr << 1;
                    end
                end else begin
                    bitc++;
                    if (bitc == 8) begin
                        bitc = 0;
                        if (ri < 1) ri++;
                        node_sr = replies[ri];
                    end else if (!m_cpha) begin
                        node_sr = node_sr << 1;
                    end
                    if (!m_cpha) miso = node_sr[7];
                end
            end
        end
        prev_busy = busy; prev_sclk = sclk; prev_mosi = mosi; prev_cs = cs_n;

        if (busy_b && !prev_busy_b) tog_b = 0;
        if (prev_busy_b && sclk_b != prev_sclk_b) tog_b++;
        if (cs_n_b != 3'b111) cs_low_b++;
        if (rsp_valid_b) begin
            rsp_cnt_b++; last_rsp_b = rsp_data_b;
        end
        prev_busy_b = busy_b; prev_sclk_b = sclk_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input bit sel, input logic [1:0] node, input logic cpol, input logic cpha,
                          input logic [7:0] div, input logic [7:0] data, input logic last,
                          output bit ok);
        @(negedge clk);
        cmd_node = node; cmd_cpol = cpol; cmd_cpha = cpha;
        cmd_div = div; cmd_data = data; cmd_last = last;
        if (sel) cmd_valid_b = 1'b1; else cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if ((sel ? cmd_ready_b : cmd_ready) === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if ((sel ? busy_b : busy) === 1'b0) ok = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    bit ok;
    int snap, snap_acc, rdy_seen;
    logic [7:0] first_rsp;

    initial begin
        replies[0] = 8'h00; replies[1] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_cs_n_async", cs_n, 4'hF);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // Mode 0, div 0, node 2
        m_cpol = 0; m_cpha = 0; exp_cs = 4'b1011; replies[0] = 8'h3C; replies[1] = 8'h3C;
        do_cmd(0, 2'd2, 0, 0, 8'd0, 8'hA5, 1, ok);
        chk("t1_accept", ok, 1);
        chk("t1_cs_low", cs_n, 4'b1011);
        wait_idle(0, ok);
        chk("t1_done", ok, 1);
        chk("t1_cs_bad", cs_bad, 0);
        chk("t1_toggles", tog_cnt, 16);
        chk("t1_min_spacing", min_sp, 1);
        chk("t1_max_spacing", max_sp, 1);
        chk("t1_mosi_at_rise", rise_word, 8'hA5);
        chk("t1_mosi_chg_rise", mosi_rise_chg, 0);
        chk("t1_rsp_pulses", rsp_hi, 1);
        chk("t1_rsp_data", last_rsp, 8'h3C);
        chk("t1_rsp_after_last_edge", rsp_cyc, last_tog + 1);
        chk("t1_cs_released", cs_n, 4'hF);
        chk("t1_mosi_idle", mosi, 1'b0);

        // Mode 3, div 3, node 0
        m_cpol = 1; m_cpha = 1; exp_cs = 4'b1110; replies[0] = 8'hFF; replies[1] = 8'hFF;
        do_cmd(0, 2'd0, 1, 1, 8'd3, 8'h81, 1, ok);
        chk("t2_accept", ok, 1);
        chk("t2_sclk_idle_lead", sclk, 1'b1);
        wait_idle(0, ok);
        chk("t2_done", ok, 1);
        chk("t2_sclk_idle_after", sclk, 1'b1);
        chk("t2_first_edge_falling", first_dir, 1'b0);
        chk("t2_toggles", tog_cnt, 16);
        chk("t2_min_spacing", min_sp, 4);
        chk("t2_max_spacing", max_sp, 4);
        chk("t2_edge_span", last_tog - first_tog, 60);
        chk("t2_mosi_at_rise", rise_word, 8'h81);
        chk("t2_mosi_chg_rise", mosi_rise_chg, 0);
        chk("t2_rsp_data", last_rsp, 8'hFF);
        chk("t2_cs_bad", cs_bad, 0);

        // Burst to node 1
        m_cpol = 0; m_cpha = 0; exp_cs = 4'b1101; replies[0] = 8'h96; replies[1] = 8'h69;
        snap = rsp_cnt;
        do_cmd(0, 2'd1, 0, 0, 8'd1, 8'h11, 0, ok);
        chk("t3_accept1", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (rsp_cnt > snap) ok = 1'b1;
        end
        chk("t3_rsp1_seen", ok, 1);
        first_rsp = last_rsp;
        repeat (5) @(negedge clk);
        chk("t3_hold_sclk", sclk, 1'b0);
        chk("t3_hold_cs", cs_n, 4'b1101);
        chk("t3_hold_mosi", mosi, 1'b0);
        chk("t3_hold_busy", busy, 1'b1);
        chk("t3_hold_ready", cmd_ready, 1'b1);
        do_cmd(0, 2'd0, 1, 1, 8'd1, 8'h22, 1, ok);
        chk("t3_accept2", ok, 1);
        wait_idle(0, ok);
        chk("t3_done", ok, 1);
        chk("t3_rsp1_data", first_rsp, 8'h96);
        chk("t3_rsp2_data", last_rsp, 8'h69);
        chk("t3_rsp_count", rsp_cnt - snap, 2);
        chk("t3_cs_up_count", cs_up, 1);
        chk("t3_cs_bad", cs_bad, 0);
        chk("t3_toggles", tog_cnt, 32);
        chk("t3_mosi_at_rise", rise_word, 8'h22);

        // Reset in the middle of SHIFT
        m_cpol = 1; m_cpha = 0; exp_cs = 4'b1011; replies[0] = 8'hE7; replies[1] = 8'hE7;
        snap = rsp_cnt;
        do_cmd(0, 2'd2, 1, 0, 8'd1, 8'hF0, 1, ok);
        chk("t4_accept", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (tog_cnt >= 8) ok = 1'b1;
        end
        chk("t4_reached_bit4", ok, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_cs_n", cs_n, 4'hF);
        chk("t4_async_sclk", sclk, 1'b0);
        chk("t4_async_busy", busy, 1'b0);
        chk("t4_async_mosi", mosi, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_no_rsp", rsp_cnt - snap, 0);
        m_cpol = 0; m_cpha = 0; replies[0] = 8'hC3; replies[1] = 8'hC3;
        do_cmd(0, 2'd2, 0, 0, 8'd0, 8'h5A, 1, ok);
        chk("t4_accept_after", ok, 1);
        wait_idle(0, ok);
        chk("t4_done_after", ok, 1);
        chk("t4_rsp_data_after", last_rsp, 8'hC3);
        chk("t4_mosi_after", rise_word, 8'h5A);

        // cmd_valid held through a transfer
        exp_cs = 4'b0111; replies[0] = 8'hAA; replies[1] = 8'hAA;
        snap = rsp_cnt;
        do_cmd(0, 2'd3, 0, 0, 8'd0, 8'hC3, 1, ok);
        chk("t5_accept1", ok, 1);
        snap_acc = acc_cnt;
        cmd_data = 8'h55; cmd_valid = 1'b1;
        rdy_seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
            else if (cmd_ready !== 1'b0) rdy_seen++;
        end
        chk("t5_reached_idle", ok, 1);
        chk("t5_ready_low_while_busy", rdy_seen, 0);
        chk("t5_ready_in_idle", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("t5_busy_after_accept", busy, 1'b1);
        wait_idle(0, ok);
        chk("t5_done", ok, 1);
        chk("t5_accept_once", acc_cnt - snap_acc, 1);
        chk("t5_mosi_second", rise_word, 8'h55);
        chk("t5_rsp_count", rsp_cnt - snap, 2);
        chk("t5_cs_bad", cs_bad, 0);

        // Out-of-range node on the three-node instance
        do_cmd(1, 2'd3, 0, 0, 8'd0, 8'h3C, 1, ok);
        chk("t6_accept", ok, 1);
        wait_idle(1, ok);
        chk("t6_done", ok, 1);
        chk("t6_cs_never_low", cs_low_b, 0);
        chk("t6_toggles", tog_b, 16);
        chk("t6_rsp_count", rsp_cnt_b, 1);
        chk("t6_rsp_data", last_rsp_b, 8'hFF);
        chk("onehot_cs", onehot_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
